fetch_unit: RTL and testbench

//   Owns the architectural PC register and the instruction-fetch handshake of the 8-bit core.

---
 rtl/redux_pkg.sv | 17 +
 rtl/pc_reg.sv | 23 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/redux_pkg.sv
// Shared definitions for the 8-bit core's front end.
// Holds the default address/instruction widths, the reset PC and the
// fetch FSM state type used by fetch_unit.
package redux_pkg;

    localparam int             ADDR_W   = 8;
    localparam int             INSTR_W  = 8;
    localparam logic [7:0]     RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC flop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_VAL)
//   load       : capture d on the next rising edge
//   d          : next PC value
//   q          : current PC
module pc_reg #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= RESET_VAL;
        else if (load) q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Front end of the 8-bit core: owns the PC, fetches from instruction
// memory with a req/ack handshake and holds the fetched word for decode
// under a valid/ready handshake.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   n_pc / cur_pc           : next PC from next_pc / architectural PC to next_pc
//   imem_req/addr/ack/rdata : instruction memory handshake
//   instr/instr_valid/ready : held instruction and decode handshake
//   halt / halted           : stop request (level) / halted status
//   retired                 : accepted-instruction count, wraps
module fetch_unit #(
    parameter int                ADDR_W   = redux_pkg::ADDR_W,
    parameter int                INSTR_W  = redux_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(redux_pkg::RESET_PC),
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  n_pc,
    output logic [ADDR_W-1:0]  cur_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               halt,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    import redux_pkg::*;

    state_t state, state_nxt;
    logic   accept;
    logic   capture;

    // Outputs decode straight from the state register so an asynchronous
    // reset drops the request in the same instant.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: begin
                // halt is not looked at: an issued fetch always completes
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt) state_nxt = S_FETCH;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BOOT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       instr <= '0;
        else if (capture) instr <= imem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= '0;
        else if (accept) retired <= retired + CNT_W'(1);
    end

    // n_pc is taken as-is; any wrap or branch arithmetic lives in next_pc.
    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .d     (n_pc),
        .q     (cur_pc)
    );

    assign imem_addr = cur_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int         AW    = 8;
    localparam int         IW    = 8;
    localparam int         CW    = 4;       // narrow counter so wrap is reached
    localparam logic [7:0] RPC   = 8'h00;
    localparam int         NCYC  = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] n_pc;
    logic [AW-1:0] cur_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          halt;
    logic          halted;
    logic [CW-1:0] retired;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .n_pc        (n_pc),
        .cur_pc      (cur_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halt        (halt),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the front end is either just out of reset (one dead
    // cycle), waiting on memory, holding a word for decode, or parked.
    bit         m_boot;
    bit         m_have;
    bit         m_park;
    int         m_pc;
    int         m_instr;
    int         m_ret;
    int         n_acc;

    function automatic bit m_fetching();
        return !m_boot && !m_have && !m_park;
    endfunction

    task automatic m_reset();
        m_boot  = 1;
        m_have  = 0;
        m_park  = 0;
        m_pc    = RPC;
        m_instr = 0;
        m_ret   = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs the DUT saw.
    task automatic m_step();
        if (m_boot) begin
            m_boot = 0;
        end else if (m_have) begin
            if (instr_ready) begin
                m_pc   = n_pc;
                m_ret  = (m_ret + 1) % (1 << CW);
                m_have = 0;
                m_park = halt;
                n_acc++;
            end
        end else if (m_park) begin
            if (!halt) m_park = 0;
        end else if (imem_ack) begin
            m_instr = imem_rdata;
            m_have  = 1;
        end
    endtask

    task automatic chk_all(input string pfx);
        chk({pfx, ".req"},    imem_req,    m_fetching());
        chk({pfx, ".addr"},   imem_addr,   m_pc);
        chk({pfx, ".pc"},     cur_pc,      m_pc);
        chk({pfx, ".valid"},  instr_valid, m_have);
        chk({pfx, ".halted"}, halted,      m_park);
        chk({pfx, ".instr"},  instr,       m_instr);
        chk({pfx, ".ret"},    retired,     m_ret);
    endtask

    task automatic rand_inputs();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       n_pc = 8'h00;
            1:       n_pc = 8'hFF;
            2:       n_pc = 8'hFC;       // imm = -4 style target
            3:       n_pc = cur_pc + 8'd1;
            default: n_pc = 8'($urandom);
        endcase
        imem_ack    = ($urandom_range(0, 2) != 0);
        imem_rdata  = 8'($urandom);
        instr_ready = ($urandom_range(0, 2) == 0);
        halt        = ($urandom_range(0, 9) == 0) ? ~halt : halt;
    endtask

    int  rst_cnt = 0;
    int  halt_seen = 0;

    initial begin
        rst_n       = 1'b0;
        n_pc        = '0;
        imem_ack    = 1'b1;
        imem_rdata  = 8'hA5;
        instr_ready = 1'b0;
        halt        = 1'b0;
        n_acc       = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;

        // Zero-wait memory returning 0xA5 straight after reset.
        @(posedge clk); m_step();                // boot cycle
        @(negedge clk);
        chk("boot.req", imem_req, 1'b1);
        chk("boot.addr", imem_addr, 8'h00);
        @(posedge clk); m_step();
        @(negedge clk);
        chk("first.instr", instr, 8'hA5);
        chk("first.valid", instr_valid, 1'b1);

        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            chk_all("run");
            if (halted) halt_seen++;
            // Reset asserted asynchronously in the middle of a fetch.
            if (i % 600 == 300 && m_fetching()) begin
                #2 rst_n = 1'b0;
                #1;
                m_reset();
                chk("arst.req", imem_req, 1'b0);
                chk("arst.pc", cur_pc, RPC);
                @(negedge clk);
                imem_ack = 1'b1;                 // stray ack must be ignored
                chk_all("arst");
                rst_n = 1'b1;
                rst_cnt++;
                @(posedge clk); m_step();
                continue;
            end
            rand_inputs();
            @(posedge clk);
            m_step();
        end

        @(negedge clk);
        chk_all("final");
        if (n_acc < 50 || rst_cnt == 0 || halt_seen == 0) begin
            n_err++;
            $display("FAIL coverage: accepts %0d resets %0d halted cycles %0d", n_acc, rst_cnt, halt_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
